sram_req_ctrl: RTL and testbench

Request-side front end for the `sram_rw` external-SRAM port. Accepts valid/ready read and write requests from core logic and drives the `sram_rw` request pins (`read`/`addr`/`wdata`). Consumes its fixed-latency, non-backpressurable read-data return and buffers read data in a response FIFO so downstream may stall. Read issue is credit-gated so no returning read data is ever dropped.

---
 rtl/sram_ctrl_pkg.sv | 13 +
 rtl/sram_rsp_fifo.sv | 54 +++++
 rtl/sram_req_ctrl.sv | 84 ++++++++
 tb/tb_sram_req_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared widths and request type for sram_rw users
package sram_ctrl_pkg;

    localparam int SramAddrWidth = 14;
    localparam int SramDataWidth = 8;

    typedef struct packed {
        logic                     we;
        logic [SramAddrWidth-1:0] addr;
        logic [SramDataWidth-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - first-word fall-through response FIFO
// Depth must be a power of two so the pointers wrap by plain overflow.
module sram_rsp_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = $clog2(Depth) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PtrW'(1);
            end
            if (pop) begin
                rptr <= rptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rptr];
    assign full  = (count == CntW'(Depth));
    assign empty = (count == '0);

endmodule

// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - request front end for the sram_rw port
// Every non-write cycle is a read; a 2-deep tag pipe marks which returns are real.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                   AddrWidth = SramAddrWidth,
    parameter int                   DataWidth = SramDataWidth,
    parameter int                   RspDepth  = 4,
    parameter logic [AddrWidth-1:0] IdleAddr  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 mem_read_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 err_o
);

    localparam int CntW = $clog2(RspDepth) + 1;

    logic            accept;
    logic            tag0;
    logic            tag1;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic [CntW:0]   committed;

    // One extra bit: a full FIFO plus two reads in flight must not wrap.
    assign committed   = {1'b0, fifo_count} + (CntW + 1)'(tag0) + (CntW + 1)'(tag1);
    assign req_ready_o = req_we_i || (committed < (CntW + 1)'(RspDepth));
    assign accept      = req_valid_i && req_ready_o;

    assign mem_read_o  = !(accept && req_we_i);
    assign mem_addr_o  = accept ? req_addr_i : IdleAddr;
    assign mem_wdata_o = req_wdata_i;

    assign push        = tag1;
    assign rsp_valid_o = !fifo_empty;
    assign pop         = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag0  <= 1'b0;
            tag1  <= 1'b0;
            err_o <= 1'b0;
        end else begin
            tag0 <= accept && !req_we_i;
            tag1 <= tag0;
            // A missing read_valid on a real return, or an overflow the credit rule should prevent.
            if ((tag1 && !mem_rvalid_i) || (push && fifo_full && !pop)) begin
                err_o <= 1'b1;
            end
        end
    end

    sram_rsp_fifo #(
        .Width (DataWidth),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (push),
        .push_data (mem_rdata_i),
        .pop       (pop),
        .head      (rsp_rdata_o),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - directed checks of sram_req_ctrl with an sram_rw model attached
`timescale 1ns/1ps
module tb_sram_req_ctrl;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic          ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          mem_read;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          err;

    always #5 clk = ~clk;

    sram_req_ctrl #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .RspDepth  (4),
        .IdleAddr  ('0)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (valid),
        .req_ready_o  (ready),
        .req_we_i     (we),
        .req_addr_i   (addr),
        .req_wdata_i  (wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .mem_read_o   (mem_read),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .err_o        (err)
    );

    // sram_rw model: address sampled at an edge, data and read_valid out after the next edge.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] rd_q;
    logic          rv_q = 1'b0;
    logic          kill_rvalid = 1'b0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] <= i[7:0];
        mem_rvalid <= 1'b0;
    end

    always @(posedge clk) begin
        if (!mem_read) sram[mem_addr] <= mem_wdata;
        rd_q       <= sram[mem_addr];
        mem_rdata  <= rd_q;
        rv_q       <= mem_read;
        mem_rvalid <= rv_q && !kill_rvalid;
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    logic [DW-1:0] exp_q[$];
    bit mon_en    = 1'b0;
    int n_pops    = 0;
    int first_pop = 0;
    int last_pop  = 0;
    int cyc       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got 0x%0h, expected no response", rsp_rdata);
            end else begin
                check("rsp_data", rsp_rdata, exp_q.pop_front());
            end
            if (n_pops == 0) first_pop = cyc;
            last_pop = cyc;
            n_pops++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          v;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          exp_read;
        logic [AW-1:0] exp_addr;
        logic          exp_ready;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int w;
        valid = 0; we = 0; addr = '0; wdata = '0; rsp_ready = 0; rst_n = 0;

        repeat (3) @(posedge clk);
        #3;
        check("rst_mem_read", mem_read, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_err", err, 0);
        check("rst_ready", ready, 1);
        tick();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick(); #2;
            check("idle_mem_read", mem_read, 1);
            check("idle_mem_addr", mem_addr, 0);
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_err", err, 0);
        end

        // write 0xA5 to 0x0123, read it back the next cycle
        tick();
        valid = 1; we = 1; addr = 14'h0123; wdata = 8'hA5; #2;
        check("wr_mem_read", mem_read, 0);
        check("wr_mem_addr", mem_addr, 14'h0123);
        check("wr_mem_wdata", mem_wdata, 8'hA5);
        check("wr_ready", ready, 1);
        tick();
        we = 0; #2;
        check("rd_mem_read", mem_read, 1);
        check("rd_mem_addr", mem_addr, 14'h0123);
        check("rd_ready", ready, 1);
        tick();
        valid = 0; #2;
        check("lat1_rsp_valid", rsp_valid, 0);
        check("lat1_mem_read", mem_read, 1);
        tick(); #2;
        check("lat2_rsp_valid", rsp_valid, 0);
        tick(); #2;
        check("lat3_rsp_valid", rsp_valid, 1);
        check("lat3_rdata", rsp_rdata, 8'hA5);
        rsp_ready = 1;
        tick(); #2;
        check("pop_rsp_valid", rsp_valid, 0);
        check("pop_err", err, 0);

        vecs[0]  = '{1, 1, 14'h0040, 8'h5A, 0, 14'h0040, 1, 8'h00};
        vecs[1]  = '{1, 0, 14'h0040, 8'h00, 1, 14'h0040, 1, 8'h5A};
        vecs[2]  = '{0, 0, 14'h3FFF, 8'h00, 1, 14'h0000, 1, 8'h00};
        vecs[3]  = '{1, 0, 14'h3FFF, 8'h00, 1, 14'h3FFF, 1, 8'hFF};
        vecs[4]  = '{1, 1, 14'h3FFF, 8'hC3, 0, 14'h3FFF, 1, 8'h00};
        vecs[5]  = '{1, 0, 14'h3FFF, 8'h00, 1, 14'h3FFF, 1, 8'hC3};
        vecs[6]  = '{0, 1, 14'h1111, 8'h22, 1, 14'h0000, 1, 8'h00};
        vecs[7]  = '{1, 0, 14'h0200, 8'h00, 1, 14'h0200, 1, 8'h00};
        vecs[8]  = '{1, 1, 14'h0200, 8'h99, 0, 14'h0200, 1, 8'h00};
        vecs[9]  = '{1, 0, 14'h0200, 8'h00, 1, 14'h0200, 1, 8'h99};
        vecs[10] = '{1, 0, 14'h0123, 8'h00, 1, 14'h0123, 1, 8'hA5};

        mon_en = 1;
        for (int i = 0; i < 11; i++) begin
            tick();
            valid = vecs[i].v; we = vecs[i].w; addr = vecs[i].a; wdata = vecs[i].d; #2;
            check("vec_mem_read", mem_read, vecs[i].exp_read);
            check("vec_mem_addr", mem_addr, vecs[i].exp_addr);
            check("vec_ready", ready, vecs[i].exp_ready);
            if (vecs[i].v && !vecs[i].w) exp_q.push_back(vecs[i].exp_data);
        end
        tick();
        valid = 0; we = 0;
        repeat (5) tick();
        check("vec_drained", exp_q.size(), 0);

        // back-to-back reads 0x0001..0x0010
        n_pops = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            valid = 1; we = 0; addr = AW'(k); #2;
            check("b2b_ready", ready, 1);
            exp_q.push_back(DW'(k));
        end
        tick();
        valid = 0;
        repeat (6) tick();
        #2;
        check("b2b_pops", n_pops, 16);
        check("b2b_span", last_pop - first_pop, 15);
        check("b2b_drained", exp_q.size(), 0);

        // backpressure: exactly RspDepth reads fit
        rsp_ready = 0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            valid = 1; we = 0; addr = AW'(14'h20 + acc); #2;
            if (ready) begin
                exp_q.push_back(DW'(8'h20 + acc));
                acc++;
            end
        end
        check("bp_accepts", acc, 4);
        check("bp_ready_blocked", ready, 0);
        check("bp_head", rsp_rdata, 8'h20);
        tick();
        we = 1; addr = 14'h0024; wdata = 8'h77; #2;
        check("bp_wr_ready", ready, 1);
        check("bp_wr_mem_read", mem_read, 0);
        tick();
        we = 0; addr = 14'h0024; #2;
        check("bp_rd_blocked", ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        exp_q.push_back(8'h77);
        rsp_ready = 1;
        w = 0;
        while (!ready && w < 10) begin
            tick(); #2;
            w++;
        end
        check("bp_resume", ready, 1);
        tick();
        valid = 0;
        repeat (6) tick();
        check("bp_drained", exp_q.size(), 0);

        // err_o: dummy returns with read_valid low are ignored, a real one is flagged
        kill_rvalid = 1;
        for (int i = 0; i < 4; i++) begin
            tick(); #2;
            check("err_dummy", err, 0);
        end
        tick();
        valid = 1; we = 0; addr = 14'h0077;
        exp_q.push_back(8'h77);
        tick();
        valid = 0; #2;
        check("err_e0", err, 0);
        tick(); #2;
        check("err_e1", err, 0);
        tick(); #2;
        check("err_set", err, 1);
        kill_rvalid = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); #2;
            check("err_sticky", err, 1);
        end

        // reset with two reads in flight
        mon_en = 0;
        rsp_ready = 0;
        tick();
        valid = 1; we = 0; addr = 14'h0010;
        tick();
        addr = 14'h0011;
        tick();
        valid = 0; rst_n = 0; #2;
        check("mid_rst_err", err, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_mem_read", mem_read, 1);
        tick();
        rst_n = 1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            tick(); #2;
            check("post_rst_rsp_valid", rsp_valid, 0);
        end
        tick();
        valid = 1; we = 0; addr = 14'h0055;
        tick();
        valid = 0;
        tick();
        tick(); #2;
        check("post_rst_rd_valid", rsp_valid, 1);
        check("post_rst_rd_data", rsp_rdata, 8'h55);
        tick(); #2;
        check("post_rst_hold_valid", rsp_valid, 1);
        check("post_rst_hold_data", rsp_rdata, 8'h55);
        rsp_ready = 1;
        tick(); #2;
        check("post_rst_count1", rsp_valid, 0);
        check("post_rst_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
